// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg: opcodes, format/error enums and field packing shared by the immediate encoder
package riscv_imm_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD} imm_fmt_e;
  typedef enum logic [1:0] {ERR_OK, ERR_RANGE, ERR_ALIGN, ERR_OPCODE} imm_err_e;

  // jalr with a nonzero funct3 is not a legal jalr, so it is packed as a branch
  function automatic imm_fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_IMM || op == OP_LOAD) ? FMT_I :
           op == OP_JALR   ? (f3 == 3'd0 ? FMT_I : FMT_SB) :
           op == OP_STORE  ? FMT_S :
           op == OP_BRANCH ? FMT_SB :
           op == OP_LUI    ? FMT_U :
           op == OP_JAL    ? FMT_UJ : FMT_BAD;
  endfunction

  function automatic logic [31:0] pack(input imm_fmt_e fmt, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [31:0] imm);
    return fmt == FMT_I  ? {imm[11:0], rs1, f3, rd, op} :
           fmt == FMT_S  ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
           fmt == FMT_SB ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op} :
           fmt == FMT_U  ? {imm[31:12], rd, op} :
           fmt == FMT_UJ ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, op} : NOP;
  endfunction
endpackage

// File: rtl/imm_range_check.sv
// imm_range_check: classifies a sign-extended immediate as ok / misaligned / out of range for its format
module imm_range_check
  import riscv_imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  imm_fmt_e         fmt_i,
  input  logic [XLEN-1:0]  imm_i,
  output imm_err_e         err_o
);
  logic align_bad, range_bad;

  // true when every bit from b upward equals bit b, i.e. the value is representable in b+1 signed bits
  function automatic logic fits(input logic [XLEN-1:0] v, input int b);
    logic [XLEN-1:0] t;
    t = $signed(v) >>> b;
    return t == '0 || t == '1;
  endfunction

  // low-bit granularity counts as alignment, which wins over range
  always_comb begin
    align_bad = (fmt_i == FMT_SB || fmt_i == FMT_UJ) ? imm_i[0] :
                fmt_i == FMT_U ? |imm_i[11:0] : 1'b0;
    range_bad = (fmt_i == FMT_I || fmt_i == FMT_S) ? !fits(imm_i, 11) :
                fmt_i == FMT_SB ? !fits(imm_i, 12) :
                fmt_i == FMT_UJ ? !fits(imm_i, 20) :
                fmt_i == FMT_U  ? !fits(imm_i, 31) : 1'b0;
    err_o = fmt_i == FMT_BAD ? ERR_OPCODE : align_bad ? ERR_ALIGN : range_bad ? ERR_RANGE : ERR_OK;
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready packer of immediates into RV64 instruction words (optional IMM_ENC_SELFCHECK_EN re-decode)
module imm_encoder
  import riscv_imm_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [1:0]           out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 out_mismatch
);
  logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d, s1_can, s2_load;
  logic [6:0]      s1_op_q;
  logic [4:0]      s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]      s1_f3_q;
  logic [XLEN-1:0] s1_imm_q;
  imm_fmt_e        s1_fmt_q, fmt_in;
  imm_err_e        s1_err_q, err_in;
  logic [31:0]     packed_w, s2_inst_q, s2_inst_d;
  logic [1:0]      s2_err_q, s2_err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic            unused_bits;

  assign fmt_in = fmt_of(in_opcode, in_funct3);
  assign unused_bits = ^{in_funct7, s1_imm_q[XLEN-1:32]};

  imm_range_check #(.XLEN(XLEN)) u_range (
    .fmt_i (fmt_in),
    .imm_i (in_imm),
    .err_o (err_in)
  );

  // handshake and next-state: each stage loads when empty or draining this cycle; reset blocks handshakes
  always_comb begin
    s2_load   = !s2_v_q || out_ready;
    s1_can    = !s1_v_q || s2_load;
    in_ready  = !reset && s1_can;
    out_valid = !reset && s2_v_q;
    s1_v_d    = s1_can ? in_valid : s1_v_q;
    s2_v_d    = s2_load ? s1_v_q : s2_v_q;
    packed_w  = pack(s1_fmt_q, s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q, s1_f3_q, s1_imm_q[31:0]);
    s2_inst_d = (s2_load && s1_v_q) ? (s1_err_q == ERR_OK ? packed_w : NOP) : s2_inst_q;
    s2_err_d  = (s2_load && s1_v_q) ? s1_err_q : s2_err_q;
    cnt_d     = (out_valid && out_ready && s2_err_q != 2'd0 && cnt_q != '1) ? cnt_q + ERR_CNT_W'(1) : cnt_q;
  end

  // stage1 payload capture; no reset needed since s1_v_q qualifies it
  always_ff @(posedge clk) begin
    if (s1_can) begin
      s1_op_q  <= in_opcode;
      s1_rd_q  <= in_rd;
      s1_rs1_q <= in_rs1;
      s1_rs2_q <= in_rs2;
      s1_f3_q  <= in_funct3;
      s1_imm_q <= in_imm;
      s1_fmt_q <= fmt_in;
      s1_err_q <= err_in;
    end
  end

  // valids, stage2 result and error counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_inst_q <= NOP;
      s2_err_q  <= 2'd0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      s2_inst_q <= s2_inst_d;
      s2_err_q  <= s2_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign err_count = cnt_q;

`ifdef IMM_ENC_SELFCHECK_EN
  logic s2_mis_q, s2_mis_d;

  function automatic logic [XLEN-1:0] redecode(input imm_fmt_e f, input logic [31:0] w);
    return f == FMT_I  ? {{(XLEN-12){w[31]}}, w[31:20]} :
           f == FMT_S  ? {{(XLEN-12){w[31]}}, w[31:25], w[11:7]} :
           f == FMT_SB ? {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} :
           f == FMT_U  ? {{(XLEN-32){w[31]}}, w[31:12], 12'b0} :
           f == FMT_UJ ? {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} : '0;
  endfunction

  // flag packed words whose decoded immediate differs from the request, only for error-free results
  always_comb begin
    s2_mis_d = (s2_load && s1_v_q) ? (s1_err_q == ERR_OK && redecode(s1_fmt_q, packed_w) != s1_imm_q) : s2_mis_q;
  end

  // mismatch flag travels with the stage2 result
  always_ff @(posedge clk) begin
    if (reset) s2_mis_q <= 1'b0;
    else       s2_mis_q <= s2_mis_d;
  end

  assign out_mismatch = s2_mis_q;
`else
  assign out_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed and randomized checks of imm_encoder against a scoreboard model
module tb_imm_encoder;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_mismatch;
  logic [6:0]  in_opcode = '0, in_funct7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [63:0] in_imm = '0;
  logic [31:0] out_inst;
  logic [1:0]  out_err;
  logic [15:0] err_count;

  typedef struct {logic [31:0] inst; logic [1:0] err;} exp_t;
  exp_t exp_q[$];
  int checks = 0, passed = 0, ecnt = 0, sent, cyc, lat;
  bit prev_stall = 0, acc = 0;
  logic [31:0] prev_inst;
  logic [1:0]  prev_err;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count), .out_mismatch(out_mismatch)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // reference: format by opcode, legal value sets as signed integer intervals, fields placed as documented
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    exp_t e;
    longint s;
    int fmt;
    bit al, rg;
    s = longint'(imm);
    al = 0;
    rg = 0;
    if (op == 7'h13 || op == 7'h03 || (op == 7'h67 && f3 == 3'd0)) fmt = 0;
    else if (op == 7'h23) fmt = 1;
    else if (op == 7'h63 || op == 7'h67) fmt = 2;
    else if (op == 7'h37) fmt = 3;
    else if (op == 7'h6f) fmt = 4;
    else fmt = 5;
    case (fmt)
      0, 1: rg = s < -2048 || s > 2047;
      2: begin al = s % 2 != 0; rg = s < -4096 || s > 4094; end
      3: begin al = s % 4096 != 0; rg = s < -64'sd2147483648 || s > 64'sd2147483647; end
      4: begin al = s % 2 != 0; rg = s < -64'sd1048576 || s > 64'sd1048574; end
      default: ;
    endcase
    e.err = fmt == 5 ? 2'd3 : al ? 2'd2 : rg ? 2'd1 : 2'd0;
    case (fmt)
      0: e.inst = {imm[11:0], rs1, f3, rd, op};
      1: e.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      2: e.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3: e.inst = {imm[31:12], rd, op};
      4: e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: e.inst = 32'h13;
    endcase
    if (e.err != 2'd0) e.inst = 32'h13;
    return e;
  endfunction

  // one clock: observe handshakes just before the rising edge, then advance to the next falling edge
  task automatic tick();
    exp_t e;
    #1;
    if (prev_stall) begin
      chk("stall_inst", out_inst, prev_inst);
      chk("stall_err", out_err, prev_err);
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm));
    if (out_valid && out_ready) begin
      chk("queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst", out_inst, e.inst);
        chk("err", out_err, e.err);
        chk("mismatch", out_mismatch, 0);
        if (e.err != 2'd0) ecnt++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_inst = out_inst;
    prev_err = out_err;
    @(negedge clk);
    chk("err_count", err_count, ecnt > 65535 ? 65535 : ecnt);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    in_funct7 = 7'($urandom);
  endtask

  task automatic rnd_req();
    logic [6:0] ops [8] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h33};
    longint bnd [16] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                         1048574, 1048576, -1048576, -1048578, 64'sh7FFFF000,
                         64'sh80000000, -64'sh80000000, -64'sh80001000};
    int k;
    logic [63:0] imm;
    k = $urandom_range(0, 8);
    case ($urandom_range(0, 4))
      0: imm = longint'($urandom_range(0, 8192)) - 4096;
      1: imm = {$urandom, $urandom};
      2: imm = bnd[$urandom_range(0, 15)];
      3: imm = longint'(int'($urandom & 32'hFFFFF000));
      default: imm = longint'($urandom_range(0, 4194304)) - 2097152;
    endcase
    set_req(k == 8 ? 7'($urandom) : ops[k], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
  endtask

  // single request into an empty pipe: latency and packed value against known encodings
  task automatic one(input string tag, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm,
                     input logic [31:0] want, input logic [1:0] want_err);
    set_req(op, rd, rs1, rs2, f3, imm);
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    do begin
      tick();
      in_valid = 1'b0;
      lat++;
      #1;
    end while (!out_valid && lat < 10);
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_inst"}, out_inst, want);
    chk({tag, "_err"}, out_err, want_err);
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 32'h13);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_mismatch", out_mismatch, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    one("addi",  7'h13, 5'd1, 5'd0, 5'd0, 3'd0, -64'sd1,      32'hFFF00093, 2'd0);
    one("sw",    7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 64'd8,        32'h0020A423, 2'd0);
    one("beq",   7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -64'sd4,      32'hFE000EE3, 2'd0);
    one("lui",   7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 64'h12345000, 32'h123452B7, 2'd0);
    one("range", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 64'd2048,     32'h00000013, 2'd1);
    one("align", 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 64'd3,        32'h00000013, 2'd2);
    one("badop", 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 64'd0,        32'h00000013, 2'd3);
    chk("err_count_3", err_count, 3);

    sent = 0;
    cyc = 0;
    rnd_req();
    while (sent < 8 && cyc < 100) begin
      in_valid = 1'b1;
      out_ready = (cyc % 2) == 0;
      tick();
      if (acc) begin sent++; rnd_req(); end
      cyc++;
    end
    chk("b2b_sent", sent, 8);
    drain();

    out_ready = 1'b0;
    in_valid = 1'b1;
    rnd_req();
    tick();
    rnd_req();
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    reset = 1'b1;
    exp_q.delete();
    ecnt = 0;
    prev_stall = 0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_out_inst", out_inst, 32'h13);
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) rnd_req();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
